ysyx_24090012_axi_rd_arbiter: RTL
=================================

YSYX_24090012_AXI_RD_ARBITER -- requirements
Module: ysyx_24090012_axi_rd_arbiter

Interface
REQ-001 SHALL have parameters:
- NM, default 3: number of read masters, legal 2..8.
- AW, default 32: address width.
- DW, default 32: data width.
- IDW, default 4: ID width.
- RR, default 1: arbitration mode; 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-002 SHALL use the derived widths ARW = IDW+AW+13 and RW = IDW+DW+3.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- m_arvalid  in  NM  per-master AR valid.
- m_arready  out  NM  per-master AR ready.
- m_ar  in  NM*ARW  per-master AR payload; master i at [i*ARW +: ARW], packed {id,addr,len[7:0],size[2:0],burst[1:0]}.
- m_rvalid  out  NM  per-master R valid.
- m_rready  in  NM  per-master R ready.
- m_r  out  RW  R payload {id,data,resp[1:0],last}, broadcast to all masters.
- io_master_arvalid  out  1  downstream AR valid.
- io_master_arready  in  1  downstream AR ready.
- io_master_ar  out  ARW  downstream AR payload, same packing as m_ar.
- io_master_rvalid  in  1  downstream R valid.
- io_master_rready  out  1  downstream R ready.
- io_master_r  in  RW  downstream R payload.
- grant  out  NM  one-hot current owner; all-zero in IDLE.
- busy  out  1  high in ADDR or DATA.
- err  out  1  sticky protocol-error flag.

Function
REQ-004 SHALL implement the FSM states IDLE, ADDR and DATA; only one read transaction is outstanding at any time.
REQ-005 IDLE: if any m_arvalid is high, SHALL register the winner into grant and move to ADDR next cycle; otherwise SHALL stay in IDLE.
REQ-006 RR=1: the search SHALL start at (last_winner+1) mod NM and wrap; last_winner SHALL update only on grant. RR=0: the lowest asserted index SHALL win.
REQ-007 ADDR:
- io_master_arvalid = m_arvalid[owner].
- m_arready[owner] = io_master_arready; all other m_arready bits = 0.
- io_master_ar = owner payload.
- On AR handshake: load beat counter with len, then go to DATA.
REQ-008 Latency: a request seen in IDLE at cycle t SHALL produce io_master_arvalid at cycle t+1; no combinational path from m_arvalid to io_master_arvalid.
REQ-009 DATA:
- m_rvalid[owner] = io_master_rvalid; all other m_rvalid bits = 0.
- io_master_rready = m_rready[owner].
- m_r = io_master_r.
- On each R handshake the beat counter SHALL decrement.
REQ-010 DATA exit: a handshake with last=1 SHALL return the FSM to IDLE next cycle, and the next grant decision SHALL be made in that IDLE cycle (one bubble).
REQ-011 Beat check on an R handshake: err SHALL be set if last=1 with counter≠0, or if last=0 with counter=0. The FSM SHALL still exit only on last.
REQ-012 io_master_rvalid high while in IDLE or ADDR SHALL set err; io_master_rready stays 0 in those states.
REQ-013 err SHALL clear only on rst.
REQ-014 A master dropping arvalid during ADDR SHALL NOT change the owner; the FSM waits in ADDR.
REQ-015 A simultaneous new request during DATA SHALL be held off (m_arready = 0) until the next IDLE.

Reset
REQ-016 On rst high at a clock edge, regardless of state (including mid-burst), the block SHALL reset to:
- state = IDLE, grant = 0, busy = 0, err = 0, beat counter = 0.
- last_winner = NM-1, so master 0 has first round-robin priority.
- io_master_arvalid = 0, io_master_rready = 0, m_arready = 0, m_rvalid = 0.

Verification
REQ-017 The bench SHALL cover these scenarios:
- NM=3, RR=1; all three arvalid held high, len=0 each -> grants in order 001, 010, 100, 001; each io_master_arvalid rises 1 cycle after IDLE.
- RR=0; masters 1 and 2 requesting continuously -> master 1 always granted; master 2 starves.
- len=3 burst to master 2 with io_master_rvalid toggling every other cycle -> 4 beats forwarded only to m_rvalid[2]; FSM reaches IDLE after the 4th beat; err=0.
- len=3 with last asserted on beat 2 -> err=1 sticky; FSM returns to IDLE.
- io_master_rvalid pulsed while IDLE -> err=1; io_master_rready=0.
- rst asserted in DATA after beat 1 of len=7 -> next cycle grant=0, busy=0, err=0; master 0 wins the next round-robin contest.

Source files
------------

// File: rtl/ysyx_24090012_axi_rd_arbiter.sv
// N-to-1 AXI read-channel arbiter.
// One outstanding read; round-robin or fixed-priority grant.
module ysyx_24090012_axi_rd_arbiter #(
    parameter int NM  = 3,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 4,
    parameter int RR  = 1,
    localparam int ARW = IDW + AW + 13,
    localparam int RW  = IDW + DW + 3,
    localparam int OW  = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NM-1:0]     m_arvalid,
    output logic [NM-1:0]     m_arready,
    input  logic [NM*ARW-1:0] m_ar,
    output logic [NM-1:0]     m_rvalid,
    input  logic [NM-1:0]     m_rready,
    output logic [RW-1:0]     m_r,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [ARW-1:0]    io_master_ar,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [RW-1:0]     io_master_r,
    output logic [NM-1:0]     grant,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last_win;
    logic [7:0]    cnt;

    logic [OW-1:0] win;
    logic          found;
    int unsigned   idx;

    logic          ar_hs;
    logic          r_hs;
    logic          r_last;
    logic [7:0]    ar_len;

    // Pick the next owner: rotating start after last winner, or lowest index.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NM; k++) begin
            if (RR != 0)
                idx = (int'(last_win) + 1 + k) % NM;
            else
                idx = k;
            if (!found && m_arvalid[OW'(idx)]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    // Route handshakes between the owning master and the downstream port.
    always_comb begin
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        m_arready         = '0;
        m_rvalid          = '0;
        if (state == ADDR) begin
            io_master_arvalid = m_arvalid[owner];
            m_arready[owner]  = io_master_arready;
        end
        if (state == DATA) begin
            io_master_rready = m_rready[owner];
            m_rvalid[owner]  = io_master_rvalid;
        end
    end

    assign io_master_ar = m_ar[int'(owner)*ARW +: ARW];
    assign m_r          = io_master_r;

    assign ar_len = io_master_ar[12:5];
    assign r_last = io_master_r[0];
    assign ar_hs  = (state == ADDR) && io_master_arvalid && io_master_arready;
    assign r_hs   = (state == DATA) && io_master_rvalid && io_master_rready;

    // Transaction FSM with registered grant and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            last_win <= OW'(NM - 1);
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= NM'(1) << win;
                        owner    <= win;
                        last_win <= win;
                        busy     <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        cnt   <= ar_len;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (cnt != 8'd0)
                            cnt <= cnt - 8'd1;
                        if (r_last) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error: stray R beats outside DATA, or last/beat-count disagreement.
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if ((state != DATA) && io_master_rvalid)
            err <= 1'b1;
        else if (r_hs && (r_last != (cnt == 8'd0)))
            err <= 1'b1;
    end

endmodule
